seq_loader: RTL and testbench

- Transmit side of the score bank's sequence/penalty load interface.
- Accepts a command (type, ID, length) and then a stream of 2-bit encoded bases.
- Packs them into the bank's wide load word `{hdr, ID, LEN, SEQ}` and pulses `ld_sequence` once per sequence.
- Honours the bank's `full` back-pressure for targets, and also forwards penalty sets as a one-cycle `ld_penalties` pulse.

---
 rtl/seq_loader.sv | 137 +++++++++++++
 tb/tb_seq_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_loader.sv
// Transmit side of the score bank load interface: packs a command plus its
// 2-bit base stream into {hdr, ID, LEN, SEQ} and strobes it into the bank.
module seq_loader #(
  parameter int ID_WIDTH    = 48,
  parameter int LEN_WIDTH   = 12,
  parameter int SEQ_LENGTH  = 128,
  parameter int SCORE_WIDTH = 12,
  parameter int IN_WIDTH    = 2 + ID_WIDTH + LEN_WIDTH + 2*SEQ_LENGTH,
  parameter int CNT_WIDTH   = $clog2(SEQ_LENGTH+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_is_query,
  input  logic [ID_WIDTH-1:0]      cmd_id,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  input  logic                     base_valid,
  output logic                     base_ready,
  input  logic [1:0]               base,
  input  logic                     pen_valid,
  output logic                     pen_ready,
  input  logic [4*SCORE_WIDTH-1:0] pen_in,
  input  logic                     full,
  output logic                     ld_sequence,
  output logic [0:IN_WIDTH-1]      data_in,
  output logic                     ld_penalties,
  output logic [4*SCORE_WIDTH-1:0] penalties,
  output logic                     busy,
  output logic                     overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] SEND = 2'd3;

  localparam logic [LEN_WIDTH-1:0] LEN_CAP = LEN_WIDTH'(SEQ_LENGTH);
  localparam logic [CNT_WIDTH-1:0] POS_CAP = CNT_WIDTH'(SEQ_LENGTH);

  logic [1:0]              state, state_nxt;
  logic [1:0]              hdr_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [LEN_WIDTH-1:0]    len_q;     // stored (saturated) length
  logic [LEN_WIDTH-1:0]    tot_q;     // full requested length, drives the base count
  logic [LEN_WIDTH-1:0]    cnt_q;
  logic [CNT_WIDTH-1:0]    pos_q;
  logic [0:2*SEQ_LENGTH-1] seq_q;

  logic cmd_acc, base_acc, pen_acc, last_base;
  logic [LEN_WIDTH-1:0] len_sat;
  logic [SEQ_LENGTH-1:0] slot_we;

  assign pen_ready  = rst & (state == IDLE);
  assign cmd_ready  = rst & (state == IDLE) & ~pen_valid;
  assign base_ready = rst & (state == FILL);

  assign pen_acc   = pen_valid  & pen_ready;
  assign cmd_acc   = cmd_valid  & cmd_ready;
  assign base_acc  = base_valid & base_ready;
  assign last_base = base_acc & (cnt_q == tot_q - LEN_WIDTH'(1));
  assign len_sat   = (cmd_len > LEN_CAP) ? LEN_CAP : cmd_len;

  // One write enable per base slot; once pos saturates no slot matches,
  // so surplus bases are consumed without touching the word.
  genvar k;
  generate
    for (k = 0; k < SEQ_LENGTH; k++) begin : g_slot
      assign slot_we[k] = base_acc & (pos_q == CNT_WIDTH'(k));
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_acc) state_nxt = (cmd_len != '0) ? FILL : WAIT;
      FILL: if (last_base) state_nxt = WAIT;
      WAIT: if (hdr_q == 2'b01 || !full) state_nxt = SEND;
      SEND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_q    <= '0;
      id_q     <= '0;
      len_q    <= '0;
      tot_q    <= '0;
      cnt_q    <= '0;
      pos_q    <= '0;
      overflow <= 1'b0;
    end else if (cmd_acc) begin
      hdr_q <= cmd_is_query ? 2'b01 : 2'b10;
      id_q  <= cmd_id;
      len_q <= len_sat;
      tot_q <= cmd_len;
      cnt_q <= '0;
      pos_q <= '0;
      if (cmd_len > LEN_CAP) overflow <= 1'b1;
    end else if (base_acc) begin
      cnt_q <= cnt_q + LEN_WIDTH'(1);
      if (pos_q != POS_CAP) pos_q <= pos_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_q <= '0;
    end else begin
      for (int i = 0; i < SEQ_LENGTH; i++) begin
        if (cmd_acc)         seq_q[2*i +: 2] <= 2'b00;
        else if (slot_we[i]) seq_q[2*i +: 2] <= base;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      penalties    <= '0;
      ld_penalties <= 1'b0;
    end else begin
      ld_penalties <= pen_acc;
      if (pen_acc) penalties <= pen_in;
    end
  end

  assign data_in     = {hdr_q, id_q, len_q, seq_q};
  assign ld_sequence = (state == SEND);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_seq_loader.sv
// Scoreboard bench for seq_loader: expected load words are queued at stimulus
// time and compared when ld_sequence fires.
module tb_seq_loader;
  localparam int IDW = 8, LW = 4, SL = 4, SW = 4, IW = 22;

  logic          clk = 1'b0, rst = 1'b0;
  logic          cmd_valid = 0, cmd_is_query = 0, base_valid = 0, pen_valid = 0, full = 0;
  logic [IDW-1:0] cmd_id = '0;
  logic [LW-1:0]  cmd_len = '0;
  logic [1:0]     base = '0;
  logic [4*SW-1:0] pen_in = '0;
  logic          cmd_ready, base_ready, pen_ready, ld_sequence, ld_penalties, busy, overflow;
  logic [0:IW-1] data_in;
  logic [4*SW-1:0] penalties;

  seq_loader #(.ID_WIDTH(IDW), .LEN_WIDTH(LW), .SEQ_LENGTH(SL), .SCORE_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_query(cmd_is_query),
    .cmd_id(cmd_id), .cmd_len(cmd_len),
    .base_valid(base_valid), .base_ready(base_ready), .base(base),
    .pen_valid(pen_valid), .pen_ready(pen_ready), .pen_in(pen_in),
    .full(full), .ld_sequence(ld_sequence), .data_in(data_in),
    .ld_penalties(ld_penalties), .penalties(penalties),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [IW-1:0] sb[$];

  // Passive monitor: pulse count, overlap and pulse-width flags.
  int   ld_cnt = 0;
  logic excl_bad = 0, wide_bad = 0, prev_ld = 0;
  always @(negedge clk) begin
    if (ld_sequence) ld_cnt++;
    if (ld_sequence && ld_penalties) excl_bad = 1;
    if (ld_sequence && prev_ld) wide_bad = 1;
    prev_ld = ld_sequence;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic q, input logic [IDW-1:0] id, input logic [LW-1:0] len,
                          output int acc);
    logic got;
    int c;
    acc = -1;
    cmd_valid = 1; cmd_is_query = q; cmd_id = id; cmd_len = len;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); got = cmd_ready; c = cyc;
      @(posedge clk); #1;
      if (got) begin acc = c; break; end
    end
    cmd_valid = 0;
    if (acc < 0) chk("cmd_timeout", 0, 1);
  endtask

  task automatic send_base(input logic [1:0] b, output int acc);
    logic got;
    int c;
    acc = -1;
    base_valid = 1; base = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); got = base_ready; c = cyc;
      @(posedge clk); #1;
      if (got) begin acc = c; break; end
    end
    base_valid = 0;
    if (acc < 0) chk("base_timeout", 0, 1);
  endtask

  // Waits for the next strobe, pops the scoreboard and checks word and latency.
  task automatic wait_ld(input int exp_cyc);
    logic hit = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ld_sequence) begin
        hit = 1;
        chk("ld_lat", 64'(cyc), 64'(exp_cyc));
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else chk("data_in", 64'(data_in), 64'(sb.pop_front()));
        break;
      end
    end
    if (!hit) chk("ld_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  int a, m, n, c0;
  localparam logic [1:0] BA = 2'b10, BG = 2'b11, BT = 2'b00, BC = 2'b01;

  initial begin
    // Reset: readies forced low even with requests pending.
    cmd_valid = 1; pen_valid = 1; base_valid = 1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_pen_ready", pen_ready, 0);
    chk("rst_base_ready", base_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_in", 64'(data_in), 0);
    chk("rst_ld", {ld_sequence, ld_penalties}, 0);
    chk("rst_ovf_pen", {overflow, penalties}, 0);
    @(posedge clk); #1;
    rst = 1; cmd_valid = 0; pen_valid = 0; base_valid = 0;
    @(posedge clk); #1;

    // 1: target A,G,T
    sb.push_back(22'b10_10100101_0011_10110000);
    send_cmd(0, 8'hA5, 4'd3, a);
    send_base(BA, m); send_base(BG, m); send_base(BT, m);
    wait_ld(m + 2);
    @(negedge clk); chk("t1_busy", busy, 0);
    @(posedge clk); #1;

    // 2: query ignores full
    full = 1;
    sb.push_back(22'b01_00111100_0100_01011110);
    send_cmd(1, 8'h3C, 4'd4, a);
    send_base(BC, m); send_base(BC, m); send_base(BG, m); send_base(BA, m);
    wait_ld(m + 2);

    // 3: target held by full
    sb.push_back(22'b10_01011010_0001_11000000);
    send_cmd(0, 8'h5A, 4'd1, a);
    send_base(BG, m);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_ld", ld_sequence, 0);
      chk("t3_hold_data", 64'(data_in), 64'(sb[0]));
      chk("t3_hold_cmd_ready", cmd_ready, 0);
      @(posedge clk); #1;
    end
    full = 0; c0 = cyc;
    wait_ld(c0 + 1);

    // 4: overflow, surplus bases dropped
    chk("t4_ovf_before", overflow, 0);
    sb.push_back(22'b10_00001111_0100_01011111);
    send_cmd(0, 8'h0F, 4'd6, a);
    send_base(BC, m); send_base(BC, m); send_base(BG, m);
    send_base(BG, m); send_base(BA, m); send_base(BA, m);
    chk("t4_ovf", overflow, 1);
    wait_ld(m + 2);
    chk("t4_ovf_sticky", overflow, 1);

    // 5: penalty wins simultaneous request
    pen_valid = 1; pen_in = 16'h1234;
    cmd_valid = 1; cmd_is_query = 0; cmd_id = 8'h11; cmd_len = 4'd0;
    sb.push_back(22'b10_00010001_0000_00000000);
    @(negedge clk);
    chk("t5_pen_ready", pen_ready, 1);
    chk("t5_cmd_blocked", cmd_ready, 0);
    @(posedge clk); #1; pen_valid = 0;
    @(negedge clk);
    chk("t5_ld_pen", ld_penalties, 1);
    chk("t5_penalties", penalties, 16'h1234);
    chk("t5_cmd_ready", cmd_ready, 1);
    n = cyc;
    @(posedge clk); #1; cmd_valid = 0;
    @(negedge clk);
    chk("t5_ld_pen_pulse", ld_penalties, 0);
    chk("t5_busy", busy, 1);
    wait_ld(n + 2);

    // 6: reset mid-fill drops the partial sequence
    send_cmd(0, 8'h77, 4'd4, a);
    send_base(BG, m); send_base(BC, m);
    c0 = ld_cnt;
    rst = 0; #1;
    chk("t6_busy", busy, 0);
    chk("t6_data_in", 64'(data_in), 0);
    chk("t6_ready", {cmd_ready, pen_ready, base_ready}, 0);
    chk("t6_ovf_clr", overflow, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    repeat (3) @(posedge clk); #1;
    chk("t6_no_ld", 64'(ld_cnt), 64'(c0));
    sb.push_back(22'b10_10011001_0000_00000000);
    send_cmd(0, 8'h99, 4'd0, n);
    wait_ld(n + 2);

    repeat (3) @(posedge clk);
    chk("ld_total", 64'(ld_cnt), 6);
    chk("sb_left", 64'(sb.size()), 0);
    chk("ld_excl", excl_bad, 0);
    chk("ld_width", wide_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
